// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - N-channel PWM generator with shared prescaler and period counter
// Edge- or center-aligned; period, mode and duties are double-buffered and swap at period boundaries.
module pwm_multi_channel #(
    parameter int N_CH     = 18,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 10000,
    parameter int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEN,
    input  logic             iMODE,
    input  logic [CNT_W-1:0] iPERIOD,
    input  logic             iWR,
    input  logic [SEL_W-1:0] iCH_SEL,
    input  logic [CNT_W-1:0] iDUTY,
    output logic [N_CH-1:0]  oPWM,
    output logic             oSYNC
);

    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc;
    logic             tick;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_down;
    logic             dir_nxt;
    logic             boundary;
    logic [CNT_W-1:0] period_act;
    logic             mode_act;
    logic [CNT_W-1:0] duty_sh  [N_CH];
    logic [CNT_W-1:0] duty_act [N_CH];
    logic [N_CH-1:0]  pwm_cmp;

    assign tick = (psc == PSC_MAX);

    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir_down;
        boundary = 1'b0;
        if (tick) begin
            if (!mode_act) begin
                if (cnt >= period_act) begin
                    cnt_nxt  = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                if (period_act == '0) begin
                    cnt_nxt = '0;
                end else if (!dir_down && cnt < period_act) begin
                    cnt_nxt = cnt + 1'b1;
                end else if (!dir_down) begin
                    cnt_nxt = period_act - 1'b1;
                    dir_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
                // Returning to zero closes a center-aligned period, including P=0 and P=1.
                if (cnt_nxt == '0) begin
                    boundary = 1'b1;
                    dir_nxt  = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pwm_cmp = '0;
        for (int i = 0; i < N_CH; i++) begin
            pwm_cmp[i] = (cnt < duty_act[i]);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            psc        <= '0;
            cnt        <= '0;
            dir_down   <= 1'b0;
            period_act <= '0;
            mode_act   <= 1'b0;
            oPWM       <= '0;
            oSYNC      <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty_sh[i]  <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (iWR && (32'(iCH_SEL) < N_CH)) begin
                duty_sh[iCH_SEL] <= iDUTY;
            end
            if (!iEN) begin
                psc        <= '0;
                cnt        <= '0;
                dir_down   <= 1'b0;
                period_act <= iPERIOD;
                mode_act   <= iMODE;
                duty_act   <= duty_sh;
                oPWM       <= '0;
                oSYNC      <= 1'b0;
            end else begin
                psc      <= tick ? '0 : psc + 1'b1;
                cnt      <= cnt_nxt;
                dir_down <= dir_nxt;
                // Actives take the pre-write shadow value, so a boundary-cycle write waits a period.
                if (boundary) begin
                    period_act <= iPERIOD;
                    mode_act   <= iMODE;
                    duty_act   <= duty_sh;
                end
                oPWM  <= pwm_cmp;
                oSYNC <= boundary;
            end
        end
    end

endmodule
